// File: rtl/operand_entry_ctrl_if.sv
// rtl/operand_entry_ctrl_if.sv - keypad and converter-side signals of the operand entry sequencer
interface operand_entry_ctrl_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       is_signed;
  logic       i_ce;
  logic       a;
  logic       b;
  logic       operand_sel;
  logic       operands_valid;

  modport slave (
    input  key_valid, key_code,
    output key_ready, hundreds, tens, ones, is_signed,
           i_ce, a, b, operand_sel, operands_valid
  );

  modport master (
    output key_valid, key_code,
    input  key_ready, hundreds, tens, ones, is_signed,
           i_ce, a, b, operand_sel, operands_valid
  );
endinterface

// File: rtl/operand_entry_ctrl.sv
// rtl/operand_entry_ctrl.sv - collects two signed 3-digit operands and sequences the BCD-to-binary converter
module operand_entry_ctrl #(
  parameter int CONV_CYCLES = 3
) (
  input logic                  CLK,
  input logic                  RST,
  operand_entry_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {ENTRY, CONVERT, DONE} state_t;

  localparam int            CW        = $clog2(CONV_CYCLES + 1);
  localparam logic [CW-1:0] LAST      = CW'(CONV_CYCLES - 1);
  localparam bit            ONE_CYCLE = (CONV_CYCLES == 1);

  state_t        state;
  logic [1:0]    count;
  logic [CW-1:0] cyc;
  logic          take;

  assign take = bus.key_valid && bus.key_ready && (state == ENTRY);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state              <= ENTRY;
      count              <= 2'd0;
      cyc                <= '0;
      bus.key_ready      <= 1'b0;
      bus.hundreds       <= 4'd0;
      bus.tens           <= 4'd0;
      bus.ones           <= 4'd0;
      bus.is_signed      <= 1'b0;
      bus.i_ce           <= 1'b0;
      bus.a              <= 1'b0;
      bus.b              <= 1'b0;
      bus.operand_sel    <= 1'b0;
      bus.operands_valid <= 1'b0;
    end else begin
      case (state)
        ENTRY: begin
          bus.key_ready <= 1'b1;
          if (take) begin
            if (bus.key_code <= 4'd9) begin
              if (count != 2'd3) begin
                bus.hundreds <= bus.tens;
                bus.tens     <= bus.ones;
                bus.ones     <= bus.key_code;
                count        <= count + 2'd1;
              end
            end else if (bus.key_code == 4'hA) begin
              bus.is_signed <= ~bus.is_signed;
            end else if (bus.key_code == 4'hB) begin
              bus.hundreds  <= 4'd0;
              bus.tens      <= 4'd0;
              bus.ones      <= 4'd0;
              bus.is_signed <= 1'b0;
              count         <= 2'd0;
            end else if (bus.key_code == 4'hC) begin
              // Strobe lands on the last enable cycle, which is this one if the converter needs only one.
              state         <= CONVERT;
              cyc           <= '0;
              bus.key_ready <= 1'b0;
              bus.i_ce      <= 1'b1;
              bus.a         <= ONE_CYCLE && !bus.operand_sel;
              bus.b         <= ONE_CYCLE && bus.operand_sel;
            end
          end
        end

        CONVERT: begin
          if (cyc == LAST) begin
            bus.i_ce      <= 1'b0;
            bus.a         <= 1'b0;
            bus.b         <= 1'b0;
            bus.hundreds  <= 4'd0;
            bus.tens      <= 4'd0;
            bus.ones      <= 4'd0;
            bus.is_signed <= 1'b0;
            count         <= 2'd0;
            if (!bus.operand_sel) begin
              bus.operand_sel <= 1'b1;
              bus.key_ready   <= 1'b1;
              state           <= ENTRY;
            end else begin
              bus.operands_valid <= 1'b1;
              state              <= DONE;
            end
          end else begin
            cyc <= cyc + 1'b1;
            if ((cyc + 1'b1) == LAST) begin
              bus.a <= !bus.operand_sel;
              bus.b <= bus.operand_sel;
            end
          end
        end

        DONE: begin
          bus.operands_valid <= 1'b0;
          bus.operand_sel    <= 1'b0;
          bus.key_ready      <= 1'b1;
          state              <= ENTRY;
        end

        default: state <= ENTRY;
      endcase
    end
  end
endmodule

// File: tb/tb_operand_entry_ctrl.sv
// tb/tb_operand_entry_ctrl.sv - directed bench with a per-cycle behavioural model of operand_entry_ctrl
module tb_operand_entry_ctrl;
  localparam int CONV = 3;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  operand_entry_ctrl_if bus_if ();

  operand_entry_ctrl #(.CONV_CYCLES(CONV)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  always #5 CLK = ~CLK;

  // Model: the entry is kept as a plain integer; a digit shift is val*10+d modulo 1000.
  int m_val, m_cnt, m_busy;
  bit m_neg, m_sel, m_done, m_ready;
  logic [11:0] cap_a, cap_b;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_val <= 0; m_cnt <= 0; m_busy <= 0;
      m_neg <= 0; m_sel <= 0; m_done <= 0; m_ready <= 0;
    end else if (m_done) begin
      m_done <= 0; m_sel <= 0; m_ready <= 1;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_val <= 0; m_cnt <= 0; m_neg <= 0;
        if (!m_sel) begin
          m_sel <= 1; m_ready <= 1;
        end else begin
          m_done <= 1;
        end
      end
    end else if (!m_ready) begin
      m_ready <= 1;
    end else if (bus_if.key_valid) begin
      if (int'(bus_if.key_code) <= 9) begin
        if (m_cnt < 3) begin
          m_val <= (m_val * 10 + int'(bus_if.key_code)) % 1000;
          m_cnt <= m_cnt + 1;
        end
      end else if (bus_if.key_code == 4'hA) begin
        m_neg <= !m_neg;
      end else if (bus_if.key_code == 4'hB) begin
        m_val <= 0; m_cnt <= 0; m_neg <= 0;
      end else if (bus_if.key_code == 4'hC) begin
        m_busy <= CONV; m_ready <= 0;
      end
    end
  end

  function automatic logic [11:0] conv(input int v, input bit n);
    int r;
    r = n ? -v : v;
    return r[11:0];
  endfunction

  function automatic logic [18:0] exp_vec();
    return {4'(m_val / 100), 4'((m_val / 10) % 10), 4'(m_val % 10), m_neg,
            (m_busy > 0), (m_busy == 1) && !m_sel, (m_busy == 1) && m_sel,
            m_sel, m_done, m_ready};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {bus_if.hundreds, bus_if.tens, bus_if.ones, bus_if.is_signed,
            bus_if.i_ce, bus_if.a, bus_if.b, bus_if.operand_sel,
            bus_if.operands_valid, bus_if.key_ready};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("cycle_outputs", 32'(dut_vec()), 32'(exp_vec()));
    if (bus_if.a)
      cap_a <= conv(bus_if.hundreds * 100 + bus_if.tens * 10 + bus_if.ones, bus_if.is_signed);
    if (bus_if.b)
      cap_b <= conv(bus_if.hundreds * 100 + bus_if.tens * 10 + bus_if.ones, bus_if.is_signed);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input logic [3:0] c);
    int n;
    n = 0;
    bus_if.key_valid = 1'b1;
    bus_if.key_code  = c;
    while (!bus_if.key_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("press_timeout", 32'(n), 32'd0);
    @(negedge CLK);
    bus_if.key_valid = 1'b0;
  endtask

  initial begin
    bus_if.key_valid = 1'b0;
    bus_if.key_code  = 4'h0;
    #1 RST = 1'b1;
    #1 chk("reset_outputs", 32'(dut_vec()), 32'd0);
    @(posedge CLK);
    #2 RST = 1'b0;
    idle(2);
    chk("ready_after_reset", 32'(bus_if.key_ready), 32'd1);

    // A = 123
    press(4'h1); press(4'h2); press(4'h3);
    chk("digits_123", 32'({bus_if.hundreds, bus_if.tens, bus_if.ones}), 32'h123);
    chk("model_val_123", 32'(m_val), 32'd123);
    press(4'hC);
    chk("ce1", 32'({bus_if.i_ce, bus_if.a}), 32'b10);
    idle(1);
    chk("ce2", 32'({bus_if.i_ce, bus_if.a}), 32'b10);
    idle(1);
    chk("ce3_strobe_a", 32'({bus_if.i_ce, bus_if.a, bus_if.b}), 32'b110);
    idle(1);
    chk("after_a", 32'({bus_if.i_ce, bus_if.key_ready, bus_if.operand_sel}), 32'b011);
    chk("conv_a_123", 32'(cap_a), 32'd123);

    // B = -456, extra digit 7 dropped
    press(4'h4); press(4'h5); press(4'h6); press(4'h7);
    chk("digits_456", 32'({bus_if.hundreds, bus_if.tens, bus_if.ones}), 32'h456);
    press(4'hA); press(4'hC);
    idle(2);
    chk("strobe_b", 32'({bus_if.i_ce, bus_if.a, bus_if.b}), 32'b101);
    chk("model_b_neg456", 32'(conv(m_val, m_neg)), 32'hE38);
    idle(1);
    chk("operands_valid", 32'({bus_if.operands_valid, bus_if.key_ready}), 32'b10);
    idle(1);
    chk("after_done", 32'({bus_if.operands_valid, bus_if.operand_sel, bus_if.key_ready}), 32'b001);
    chk("conv_b_neg456", 32'(cap_b), 32'hE38);

    // Empty entry as A, double sign toggle as B
    press(4'hC);
    idle(2);
    chk("empty_strobe_a", 32'({bus_if.a, bus_if.hundreds, bus_if.tens, bus_if.ones}), 32'h1000);
    idle(1);
    chk("conv_a_zero", 32'(cap_a), 32'd0);
    press(4'hA); press(4'hA); press(4'hE); press(4'hC);
    idle(2);
    chk("sign_twice_b", 32'({bus_if.b, bus_if.is_signed}), 32'b10);
    idle(2);

    // Clear mid-entry, then clear while entering B
    press(4'h9); press(4'h9); press(4'hB); press(4'h5); press(4'hC);
    idle(3);
    chk("conv_a_5", 32'(cap_a), 32'd5);
    press(4'h9); press(4'hB);
    chk("clear_keeps_sel", 32'({bus_if.operand_sel, bus_if.hundreds, bus_if.tens, bus_if.ones}), 32'h1000);
    press(4'hC);
    idle(4);

    // Key held through CONVERT of A
    press(4'h8);
    bus_if.key_valid = 1'b1;
    bus_if.key_code  = 4'hC;
    @(negedge CLK);
    bus_if.key_code  = 4'h2;
    chk("held_c1", 32'({bus_if.key_ready, bus_if.ones}), 32'h08);
    idle(2);
    chk("held_c3", 32'({bus_if.a, bus_if.ones}), 32'h18);
    idle(1);
    chk("held_after_strobe", 32'({bus_if.key_ready, bus_if.ones}), 32'h10);
    idle(1);
    chk("held_consumed", 32'({bus_if.hundreds, bus_if.tens, bus_if.ones}), 32'h002);
    bus_if.key_valid = 1'b0;

    // Reset during the second enable cycle of B
    press(4'hC);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 chk("reset_mid_convert", 32'(dut_vec()), 32'd0);
    @(negedge CLK);
    @(posedge CLK);
    #2 RST = 1'b0;
    idle(2);
    chk("ready_after_mid_reset", 32'({bus_if.key_ready, bus_if.operand_sel, bus_if.i_ce}), 32'b100);

    press(4'h7); press(4'hC);
    idle(3);
    chk("conv_a_7_after_reset", 32'(cap_a), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/operand_entry_ctrl.md
# operand_entry_ctrl

Sequencer between the keypad decoder and the BCD-to-binary converter in the calculator datapath. It collects up to three decimal digits and a sign for each operand. On enter it drives the converter's digit, sign, enable and operand-select inputs for exactly the cycles the converter needs to load operand A, then B. When both operands are loaded it signals the ALU stage.

## Interface
Parameters:
- `CONV_CYCLES`, 3: cycles the converter needs from stable digits to a registered output; `i_ce` is held for this many cycles per load.

Ports (all outputs registered):
- `CLK`  in  1  system clock, rising edge
- `RST`  in  1  asynchronous, active-high reset
- `key_valid`  in  1  key code present this cycle
- `key_code`  in  4  0x0–0x9 digit, 0xA sign toggle, 0xB clear entry, 0xC enter; 0xD–0xF ignored
- `key_ready`  out  1  controller accepts a key; a key is taken when `key_valid && key_ready`
- `hundreds`, `tens`, `ones`  out  4 each  current entry digits, driven to the converter and the display
- `is_signed`  out  1  negate current entry; to converter
- `i_ce`  out  1  converter clock enable
- `a`, `b`  out  1 each  converter load strobes for operand A or B
- `operand_sel`  out  1  0 = entering A, 1 = entering B
- `operands_valid`  out  1  one-cycle pulse: A and B both loaded

## Operation
- States: ENTRY, CONVERT, DONE.
- ENTRY: `key_ready`=1, `i_ce`=0, `a`=`b`=0.
  - Digit d with count<3: `hundreds`←`tens`, `tens`←`ones`, `ones`←d, count+1.
  - Digit with count=3: ignored, no state change.
  - 0xA: `is_signed` toggles. Allowed at any count, including 0.
  - 0xB: digits←0, count←0, `is_signed`←0. `operand_sel` is unchanged.
  - 0xC: go to CONVERT with a cycle counter of 0. With count=0 the entry converts as 000.
  - 0xD–0xF: accepted and discarded.
- CONVERT: `key_ready`=0 and digits/sign held stable. `i_ce`=1 for `CONV_CYCLES` consecutive cycles.
  - On the last of these cycles only, `a` = !`operand_sel` and `b` = `operand_sel`.
  - After the last cycle, `i_ce`, `a` and `b` drop to 0, and digits, count and sign clear.
  - If `operand_sel`=0: `operand_sel`←1 and return to ENTRY.
  - If `operand_sel`=1: go to DONE.
- DONE: lasts exactly one cycle. `operands_valid`=1, `key_ready`=0, `operand_sel`←0, next state ENTRY.
- Keys offered while `key_ready`=0 are not consumed. The keypad source must hold them.
- Exactly one of `a`/`b` is ever high, and only while `i_ce`=1.

## Timing
- Reset (asynchronous, any state, including mid-CONVERT) sets:
  - state ENTRY
  - `hundreds`=`tens`=`ones`=0, `is_signed`=0
  - `i_ce`=0, `a`=`b`=0, `operand_sel`=0, `operands_valid`=0
  - `key_ready`=1 in the first cycle after release
- A partially loaded operand is discarded. The converter output register keeps whatever it last latched.
- Outputs change only on rising `CLK`.
  - A key accepted at edge N is reflected on the digit outputs after edge N.
  - Enter accepted at edge N: `i_ce`=1 for cycles N+1 .. N+`CONV_CYCLES`, with the strobe in cycle N+`CONV_CYCLES`.
  - The converter output is valid after edge N+`CONV_CYCLES`+1.
- `key_ready` is 1 again in the cycle after the strobe cycle when returning to ENTRY.
- `operands_valid` is high in the cycle after the B strobe. Both converter outputs are then valid.
- Minimum enter-to-enter spacing is `CONV_CYCLES`+1 cycles.

## Test plan
- Reset mid-CONVERT (during the second `i_ce` cycle): all outputs 0 on assertion, `key_ready`=1 after release, `operand_sel`=0.
- Keys 1,2,3, enter:
  - digits 1/2/3
  - `i_ce` high exactly 3 cycles, `a` only on the 3rd
  - converter A = 123
  - `operand_sel`=1, `key_ready` back high on the next cycle
- Keys 4,5,6,7 then sign, enter as B:
  - the 7 is ignored, digits stay 4/5/6
  - `b` strobed, converter B = 12'hE38 (−456)
  - `operands_valid` one-cycle pulse, then `operand_sel`=0
- Enter with no digits: converts 0, `a` strobed. Sign toggled twice then enter: `is_signed`=0 at strobe.
- Digits 9,9, clear, digit 5, enter: converter A = 5. Clear does not change `operand_sel`.
- `key_valid` held high throughout CONVERT: no key consumed and digits unchanged. The held key is consumed in the first ENTRY cycle after the strobe.
